ycc_frame_sequencer: RTL and testbench

Frame-level controller for the pixel-to-luma conversion stage of the gesture pipeline. On a start command it walks a stored RGB frame in raster order, issuing reads to the pixel RAM that feeds the converter. It tracks the fixed read-plus-convert latency and issues aligned write enables, linear addresses and (col,row) coordinates for the luma result buffer. It pulses done once every pixel has been written back.

---
 rtl/ycc_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ycc_frame_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycc_frame_sequencer.sv
// Frame sequencer for the RGB-to-luma stage: walks a frame in raster
// order, reads the pixel RAM and aligns luma-buffer writes to the converter.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin one frame (sampled only when idle)
//   hold              stall new reads; reads already in flight still drain
//   rd_en, rd_addr    registered pixel RAM read strobe and address
//   wr_en, wr_addr    luma write strobe and address, RD_LAT+CONV_LAT after the read
//   wr_col, wr_row    coordinates of the pixel being written
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   frame_cnt         completed frames, wraps modulo 256
module ycc_frame_sequencer #(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 48,
   parameter int ADDR_W   = 12,
   parameter int COL_W    = 6,
   parameter int ROW_W    = 6,
   parameter int RD_LAT   = 1,
   parameter int CONV_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [COL_W-1:0]  wr_col,
   output logic [ROW_W-1:0]  wr_row,
   output logic              busy,
   output logic              done,
   output logic [7:0]        frame_cnt
);

   localparam int D = RD_LAT + CONV_LAT;
   localparam int N = IMG_W * IMG_H;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;

   // Next pixel to be issued; rd_col/rd_row track the issued pixel.
   logic [ADDR_W-1:0] nxt_addr;
   logic [COL_W-1:0]  nxt_col;
   logic [ROW_W-1:0]  nxt_row;
   logic [COL_W-1:0]  rd_col;
   logic [ROW_W-1:0]  rd_row;

   // Delay line; the last stage drives the write outputs directly.
   logic              dl_en   [D];
   logic [ADDR_W-1:0] dl_addr [D];
   logic [COL_W-1:0]  dl_col  [D];
   logic [ROW_W-1:0]  dl_row  [D];

   assign wr_en   = dl_en[D-1];
   assign wr_addr = dl_addr[D-1];
   assign wr_col  = dl_col[D-1];
   assign wr_row  = dl_row[D-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         rd_col    <= '0;
         rd_row    <= '0;
         nxt_addr  <= '0;
         nxt_col   <= '0;
         nxt_row   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         rd_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               // Pixel 0 is issued on the accepting edge so the
               // first read lands in the first busy cycle.
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  rd_addr  <= '0;
                  rd_col   <= '0;
                  rd_row   <= '0;
                  nxt_addr <= ADDR_ONE;
                  nxt_col  <= COL_ONE;
                  nxt_row  <= '0;
               end
            end
            RUN: begin
               if (!hold) begin
                  rd_en   <= 1'b1;
                  rd_addr <= nxt_addr;
                  rd_col  <= nxt_col;
                  rd_row  <= nxt_row;
                  if (nxt_addr == LAST_ADDR) begin
                     state <= DRAIN;
                  end else begin
                     nxt_addr <= nxt_addr + ADDR_ONE;
                     if (nxt_col == LAST_COL) begin
                        nxt_col <= '0;
                        nxt_row <= nxt_row + ROW_ONE;
                     end else begin
                        nxt_col <= nxt_col + COL_ONE;
                     end
                  end
               end
            end
            DRAIN: begin
               // The final pixel leaving the delay line empties it.
               if (wr_en && (wr_addr == LAST_ADDR)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            dl_en[i]   <= 1'b0;
            dl_addr[i] <= '0;
            dl_col[i]  <= '0;
            dl_row[i]  <= '0;
         end
      end else begin
         dl_en[0]   <= rd_en;
         dl_addr[0] <= rd_addr;
         dl_col[0]  <= rd_col;
         dl_row[0]  <= rd_row;
         for (int i = 1; i < D; i++) begin
            dl_en[i]   <= dl_en[i-1];
            dl_addr[i] <= dl_addr[i-1];
            dl_col[i]  <= dl_col[i-1];
            dl_row[i]  <= dl_row[i-1];
         end
      end
   end

endmodule

// File: tb/tb_ycc_frame_sequencer.sv
// Bench for ycc_frame_sequencer: a 4x2 instance for timing/control cases
// and a default 64x48 instance for a full-frame scoreboard run.
module tb_ycc_frame_sequencer;

   localparam int SW = 4;
   localparam int SH = 2;
   localparam int SN = SW * SH;
   localparam int BW = 64;
   localparam int BH = 48;
   localparam int BN = BW * BH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int addr;
      int col;
      int row;
   } pix_t;

   // small instance
   logic       s_rst, s_start, s_hold;
   logic       s_rd_en, s_wr_en, s_busy, s_done;
   logic [2:0] s_rd_addr, s_wr_addr;
   logic [1:0] s_wr_col;
   logic [0:0] s_wr_row;
   logic [7:0] s_fc;

   ycc_frame_sequencer #(
      .IMG_W(SW), .IMG_H(SH), .ADDR_W(3), .COL_W(2), .ROW_W(1),
      .RD_LAT(1), .CONV_LAT(1)
   ) u_small (
      .clk(clk), .rst(s_rst), .start(s_start), .hold(s_hold),
      .rd_en(s_rd_en), .rd_addr(s_rd_addr),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr),
      .wr_col(s_wr_col), .wr_row(s_wr_row),
      .busy(s_busy), .done(s_done), .frame_cnt(s_fc)
   );

   // default-size instance
   logic        b_rst, b_start, b_hold;
   logic        b_rd_en, b_wr_en, b_busy, b_done;
   logic [11:0] b_rd_addr, b_wr_addr;
   logic [5:0]  b_wr_col, b_wr_row;
   logic [7:0]  b_fc;

   ycc_frame_sequencer u_big (
      .clk(clk), .rst(b_rst), .start(b_start), .hold(b_hold),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_col(b_wr_col), .wr_row(b_wr_row),
      .busy(b_busy), .done(b_done), .frame_cnt(b_fc)
   );

   pix_t s_exp[$];
   int   s_rdexp[$];
   int   s_lat_c[$], s_lat_a[$];
   int   s_rd_log[$], s_wr_log[$], s_busy_log[$], s_done_log[$];
   pix_t sp;

   pix_t b_exp[$];
   int   b_lat_c[$], b_lat_a[$];
   int   b_wr_cnt = 0;
   int   b_last_addr = -1, b_last_col = -1, b_last_row = -1;
   pix_t bp;

   int hold_rd[8] = '{1, 2, 3, 6, 7, 8, 9, 10};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int qf(input int q[$]);
      if (q.size() == 0) return -1;
      return q[0];
   endfunction

   function automatic int ql(input int q[$]);
      if (q.size() == 0) return -1;
      return q[q.size()-1];
   endfunction

   task automatic push_small();
      pix_t p;
      for (int i = 0; i < SN; i++) begin
         p.addr = i;
         p.col  = i % SW;
         p.row  = i / SW;
         s_exp.push_back(p);
         s_rdexp.push_back(i);
      end
   endtask

   task automatic push_big();
      pix_t p;
      for (int i = 0; i < BN; i++) begin
         p.addr = i;
         p.col  = i % BW;
         p.row  = i / BW;
         b_exp.push_back(p);
      end
   endtask

   task automatic clear_logs();
      s_rd_log.delete();
      s_wr_log.delete();
      s_busy_log.delete();
      s_done_log.delete();
   endtask

   always @(negedge clk) begin
      if (s_rd_en) begin
         s_rd_log.push_back(cyc);
         s_lat_c.push_back(cyc);
         s_lat_a.push_back(int'(s_rd_addr));
         chk("s_rd_pending", s_rdexp.size() > 0, 1);
         if (s_rdexp.size() > 0) chk("s_rd_addr", s_rd_addr, s_rdexp.pop_front());
      end
      if (s_wr_en) begin
         s_wr_log.push_back(cyc);
         chk("s_wr_pending", s_exp.size() > 0, 1);
         if (s_exp.size() > 0) begin
            sp = s_exp.pop_front();
            chk("s_wr_addr", s_wr_addr, sp.addr);
            chk("s_wr_col", s_wr_col, sp.col);
            chk("s_wr_row", s_wr_row, sp.row);
         end
         chk("s_lat_pending", s_lat_c.size() > 0, 1);
         if (s_lat_c.size() > 0) begin
            chk("s_lat", cyc - s_lat_c.pop_front(), 2);
            chk("s_dly_addr", s_wr_addr, s_lat_a.pop_front());
         end
      end
      if (s_busy) s_busy_log.push_back(cyc);
      if (s_done) s_done_log.push_back(cyc);
   end

   always @(negedge clk) begin
      if (b_rd_en) begin
         b_lat_c.push_back(cyc);
         b_lat_a.push_back(int'(b_rd_addr));
      end
      if (b_wr_en) begin
         b_wr_cnt++;
         b_last_addr = b_wr_addr;
         b_last_col  = b_wr_col;
         b_last_row  = b_wr_row;
         chk("b_wr_pending", b_exp.size() > 0, 1);
         if (b_exp.size() > 0) begin
            bp = b_exp.pop_front();
            chk("b_wr_addr", b_wr_addr, bp.addr);
            chk("b_wr_col", b_wr_col, bp.col);
            chk("b_wr_row", b_wr_row, bp.row);
         end
         chk("b_lat_pending", b_lat_c.size() > 0, 1);
         if (b_lat_c.size() > 0) begin
            chk("b_lat", cyc - b_lat_c.pop_front(), 2);
            chk("b_dly_addr", b_wr_addr, b_lat_a.pop_front());
         end
      end
   end

   initial begin
      int base;
      int fc0;
      int n;
      int expfc;

      s_rst = 1'b1; s_start = 1'b0; s_hold = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_hold = 1'b0;
      repeat (3) tick();
      chk("rst_small", {s_rd_en, s_rd_addr, s_wr_en, s_wr_addr, s_wr_col,
                        s_wr_row, s_busy, s_done, s_fc}, 0);
      chk("rst_big", {b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_wr_col,
                      b_wr_row, b_busy, b_done, b_fc}, 0);
      s_rst = 1'b0;
      b_rst = 1'b0;
      repeat (2) tick();

      // plain frame
      clear_logs();
      fc0 = s_fc;
      base = cyc;
      s_start = 1'b1;
      push_small();
      tick();
      s_start = 1'b0;
      repeat (14) tick();
      chk("p_rd_cnt", s_rd_log.size(), 8);
      chk("p_rd_first", qf(s_rd_log) - base, 1);
      chk("p_rd_last", ql(s_rd_log) - base, 8);
      chk("p_wr_cnt", s_wr_log.size(), 8);
      chk("p_wr_first", qf(s_wr_log) - base, 3);
      chk("p_wr_last", ql(s_wr_log) - base, 10);
      chk("p_done_cnt", s_done_log.size(), 1);
      chk("p_done_cyc", qf(s_done_log) - base, 11);
      chk("p_busy_cnt", s_busy_log.size(), 10);
      chk("p_busy_first", qf(s_busy_log) - base, 1);
      chk("p_busy_last", ql(s_busy_log) - base, 10);
      chk("p_fc", s_fc, (fc0 + 1) % 256);
      chk("p_left", s_exp.size(), 0);

      // hold for two cycles mid-frame
      clear_logs();
      fc0 = s_fc;
      base = cyc;
      for (int k = 0; k < 16; k++) begin
         s_start = (k == 0);
         s_hold  = (k == 3) || (k == 4);
         if (k == 0) push_small();
         tick();
      end
      s_start = 1'b0;
      s_hold  = 1'b0;
      chk("h_rd_cnt", s_rd_log.size(), 8);
      chk("h_wr_cnt", s_wr_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < s_rd_log.size()) chk("h_rd_cyc", s_rd_log[i] - base, hold_rd[i]);
         if (i < s_wr_log.size()) chk("h_wr_cyc", s_wr_log[i] - base, hold_rd[i] + 2);
      end
      chk("h_done_cnt", s_done_log.size(), 1);
      chk("h_done_cyc", qf(s_done_log) - base, 13);
      chk("h_fc", s_fc, (fc0 + 1) % 256);
      chk("h_left", s_exp.size(), 0);

      // starts while busy / in DONE are dropped, start in IDLE accepted
      clear_logs();
      fc0 = s_fc;
      base = cyc;
      for (int k = 0; k < 26; k++) begin
         if (k == 11) begin
            chk("i_done1", s_done, 1);
            chk("i_wr_cnt1", s_wr_log.size(), 8);
            chk("i_fc1", s_fc, (fc0 + 1) % 256);
         end
         s_start = (k == 0) || (k == 2) || (k == 11) || (k == 12);
         if (k == 0 || k == 12) push_small();
         tick();
      end
      s_start = 1'b0;
      chk("i_wr_cnt", s_wr_log.size(), 16);
      chk("i_done_cnt", s_done_log.size(), 2);
      chk("i_done2_cyc", ql(s_done_log) - base, 23);
      chk("i_fc2", s_fc, (fc0 + 2) % 256);
      chk("i_left", s_exp.size(), 0);

      // reset mid-frame
      clear_logs();
      fc0 = s_fc;
      base = cyc;
      for (int k = 0; k < 6; k++) begin
         s_start = (k == 0);
         s_rst   = (k == 5);
         if (k == 0) push_small();
         tick();
      end
      s_start = 1'b0;
      s_rst   = 1'b0;
      s_exp.delete();
      s_rdexp.delete();
      s_lat_c.delete();
      s_lat_a.delete();
      clear_logs();
      chk("r_zero", {s_rd_en, s_rd_addr, s_wr_en, s_wr_addr, s_wr_col,
                     s_wr_row, s_busy, s_done}, 0);
      chk("r_fc_zero", s_fc, 0);
      repeat (12) tick();
      chk("r_no_wr", s_wr_log.size(), 0);
      chk("r_no_rd", s_rd_log.size(), 0);
      chk("r_no_done", s_done_log.size(), 0);
      base = cyc;
      s_start = 1'b1;
      push_small();
      tick();
      s_start = 1'b0;
      repeat (14) tick();
      chk("r2_wr_cnt", s_wr_log.size(), 8);
      chk("r2_done_cyc", qf(s_done_log) - base, 11);
      chk("r2_fc", s_fc, 1);
      chk("r2_left", s_exp.size(), 0);

      // 256 back-to-back frames, frame_cnt wraps
      clear_logs();
      expfc = s_fc;
      for (int f = 0; f < 256; f++) begin
         s_start = 1'b1;
         push_small();
         tick();
         s_start = 1'b0;
         n = 0;
         while (!s_done && n < 50) begin
            tick();
            n++;
         end
         chk("w_done_seen", s_done, 1);
         expfc = (expfc + 1) % 256;
         chk("w_fc", s_fc, expfc);
         tick();
      end
      chk("w_done_cnt", s_done_log.size(), 256);
      chk("w_left", s_exp.size(), 0);

      // full default frame
      base = cyc;
      b_start = 1'b1;
      push_big();
      tick();
      b_start = 1'b0;
      n = 0;
      while (!b_done && n < BN + 20) begin
         tick();
         n++;
      end
      chk("b_done_seen", b_done, 1);
      chk("b_done_cyc", cyc - base, BN + 3);
      tick();
      chk("b_wr_cnt", b_wr_cnt, BN);
      chk("b_last_addr", b_last_addr, BN - 1);
      chk("b_last_col", b_last_col, BW - 1);
      chk("b_last_row", b_last_row, BH - 1);
      chk("b_fc", b_fc, 1);
      chk("b_left", b_exp.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
